// File: rtl/adder_subtractor.sv
// 4-bit signed adder/subtractor with a registered 5-bit result.
// Operands are sign-extended and summed through a 5-cell ripple-carry chain.
module adder_subtractor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    output logic [4:0] out
);

    logic [4:0] w_ax;
    logic [4:0] w_bx;
    logic [4:0] w_bop;
    logic [5:0] w_carry;
    logic [4:0] w_sum;
    logic [4:0] r_out;

    // Sign-extend both operands; conditionally invert B for subtraction.
    always_comb begin
        w_ax  = {a[3], a};
        w_bx  = {b[3], b};
        w_bop = w_bx ^ {5{sub}};
    end

    // Carry-in of the chain supplies the +1 of the two's complement negate.
    assign w_carry[0] = sub;

    // Ripple-carry chain of five full-adder cells; final carry-out unused.
    for (genvar gi = 0; gi < 5; gi++) begin : g_fa
        always_comb begin
            w_sum[gi]     = w_ax[gi] ^ w_bop[gi] ^ w_carry[gi];
            w_carry[gi+1] = (w_ax[gi] & w_bop[gi])
                          | (w_carry[gi] & (w_ax[gi] ^ w_bop[gi]));
        end
    end

    // Result register, cleared immediately when reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= 5'b00000;
        end else begin
            r_out <= w_sum;
        end
    end

    assign out = r_out;

    logic w_unused;
    assign w_unused = w_carry[5];

endmodule

// File: tb/tb_adder_subtractor.sv
// Self-checking bench for adder_subtractor.
// Compares against signed integer arithmetic at one-cycle latency.
module tb_adder_subtractor;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic [4:0] out;

    int n_vec;
    int n_err;

    adder_subtractor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] model(input logic [3:0] ma,
                                         input logic [3:0] mb,
                                         input logic       ms);
        int sa;
        int sb;
        int r;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        r  = ms ? (sa - sb) : (sa + sb);
        return r[4:0];
    endfunction

    // drive on negedge, check 1 time unit after the next posedge
    task automatic apply(input logic [3:0] ta, input logic [3:0] tb_,
                         input logic ts, output logic [4:0] exp_v);
        @(negedge clk);
        a   = ta;
        b   = tb_;
        sub = ts;
        exp_v = model(ta, tb_, ts);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        a = 4'b0111;
        b = 4'b0111;
        sub = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_async: out=%b expected=%b", out, 5'b00000);
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (out !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_hold: out=%b expected=%b", out, 5'b00000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (out !== 5'b01110) begin
            n_err++;
            $display("FAIL reset_release: out=%b expected=%b", out, 5'b01110);
        end
    endtask

    task automatic test_directed();
        logic [3:0] ta [8];
        logic [3:0] tbv [8];
        logic       ts [8];
        logic [4:0] te [8];
        logic [4:0] e;
        ta = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
               4'b1111, 4'b1111, 4'b1100, 4'b1100};
        tbv = '{4'b1011, 4'b1011, 4'b1010, 4'b1010,
                4'b0110, 4'b0110, 4'b0101, 4'b0101};
        ts = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        te = '{5'b11011, 5'b00101, 5'b11011, 5'b00111,
               5'b00101, 5'b11001, 5'b00001, 5'b10111};
        for (int i = 0; i < 8; i++) begin
            apply(ta[i], tbv[i], ts[i], e);
            n_vec++;
            if (out !== te[i]) begin
                n_err++;
                $display("FAIL directed_%0d: out=%b expected=%b",
                         i, out, te[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ta [4];
        logic [3:0] tbv [4];
        logic       ts [4];
        logic [4:0] te [4];
        logic [4:0] e;
        ta  = '{4'b1000, 4'b0111, 4'b1000, 4'b1000};
        tbv = '{4'b1000, 4'b1000, 4'b0111, 4'b1000};
        ts  = '{1'b0, 1'b1, 1'b1, 1'b1};
        te  = '{5'b10000, 5'b01111, 5'b10001, 5'b00000};
        for (int i = 0; i < 4; i++) begin
            apply(ta[i], tbv[i], ts[i], e);
            n_vec++;
            if (out !== te[i]) begin
                n_err++;
                $display("FAIL extreme_%0d: out=%b expected=%b",
                         i, out, te[i]);
            end
        end
    endtask

    task automatic test_hold_between_edges();
        logic [4:0] e;
        for (int i = 0; i < 8; i++) begin
            apply(4'($urandom), 4'($urandom), 1'($urandom), e);
            #1;
            a = ~a;
            b = b + 4'd3;
            sub = ~sub;
            #2;
            n_vec++;
            if (out !== e) begin
                n_err++;
                $display("FAIL hold_%0d: out=%b expected=%b", i, out, e);
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic [4:0] e;
        apply(4'b0011, 4'b0010, 1'b0, e);
        apply(4'b0111, 4'b0001, 1'b0, e);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out !== 5'b00000) begin
            n_err++;
            $display("FAIL midreset_drop: out=%b expected=%b", out, 5'b00000);
        end
        @(negedge clk);
        a = 4'b1010;
        b = 4'b0011;
        sub = 1'b1;
        rst_n = 1'b1;
        e = model(4'b1010, 4'b0011, 1'b1);
        @(posedge clk);
        #1;
        n_vec++;
        if (out !== e) begin
            n_err++;
            $display("FAIL midreset_resume: out=%b expected=%b", out, e);
        end
    endtask

    task automatic test_exhaustive();
        logic [4:0] e;
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    apply(4'(x), 4'(y), 1'(s), e);
                    n_vec++;
                    if (out !== e) begin
                        n_err++;
                        $display("FAIL exh a=%0d b=%0d sub=%0d: out=%b expected=%b",
                                 x, y, s, out, e);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] e;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rs;
        for (int i = 0; i < 200; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rs = 1'($urandom);
            apply(ra, rb, rs, e);
            n_vec++;
            if (out !== e) begin
                n_err++;
                $display("FAIL rand_%0d a=%b b=%b sub=%b: out=%b expected=%b",
                         i, ra, rb, rs, out, e);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold_between_edges();
        test_midstream_reset();
        test_exhaustive();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
